// File: rtl/cg_pkg.sv
// Shared state encoding, MISR polynomial and maximal-length LFSR tap table
// for the cg_pattern_driver slice.
package cg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_REPORT
  } cg_state_e;

  localparam logic [15:0] MISR_POLY = 16'hA011;

  function automatic logic [31:0] misr_poly(input int w);
    case (w)
      8:       return 32'h0000_001D;
      32:      return 32'h04C1_1DB7;
      default: return {16'h0000, MISR_POLY};
    endcase
  endfunction

  // Bit k-1 set means x^k appears in the feedback polynomial.
  function automatic logic [15:0] lfsr_taps(input int n);
    case (n)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0001;
    endcase
  endfunction

endpackage

// File: rtl/cg_misr.sv
// Multiple-input signature register: folds one response word per enabled
// cycle into a running signature; clear has priority over enable.
module cg_misr
  import cg_pkg::*;
#(
  parameter int MISR_W = 16,
  parameter int N_OUT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [N_OUT-1:0]  din,
  output logic [MISR_W-1:0] sig
);

  localparam logic [MISR_W-1:0] POLY = MISR_W'(misr_poly(MISR_W));

  logic [MISR_W-1:0] sig_q, sig_d, din_ext;

  always_comb begin
    din_ext = '0;
    din_ext[N_OUT-1:0] = din;
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (enable) begin
      sig_d = (sig_q << 1) ^ (sig_q[MISR_W-1] ? POLY : '0) ^ din_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/cg_pattern_driver.sv
// Applies exhaustive or LFSR vectors to a combinational circuit and compacts
// its responses into a MISR signature. CG_RESP_LOG_EN adds a response log port.
module cg_pattern_driver
  import cg_pkg::*;
#(
  parameter int N_IN   = 7,
  parameter int N_OUT  = 2,
  parameter int MISR_W = 16,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [N_IN-1:0]   seed,
  output logic [N_IN-1:0]   x,
  input  logic [N_OUT-1:0]  f,
  output logic              busy,
`ifdef CG_RESP_LOG_EN
  output logic              log_valid,
  input  logic              log_ready,
  output logic [N_IN-1:0]   log_x,
  output logic [N_OUT-1:0]  log_f,
`endif
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [MISR_W-1:0] signature,
  output logic [N_IN:0]     vec_count
);

  localparam logic [N_IN-1:0] TAPS        = N_IN'(lfsr_taps(N_IN));
  localparam logic [N_IN:0]   N_EXH       = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN:0]   ONE         = (N_IN + 1)'(1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  cg_state_e         state_q, state_d;
  logic [N_IN-1:0]   x_q, x_d, lfsr_next;
  logic              mode_q, mode_d;
  logic [N_IN:0]     vec_count_q, vec_count_d, last_count;
  logic [3:0]        settle_cnt_q, settle_cnt_d;
  logic              cap_fire, misr_clear, misr_en;

  always_comb begin
    lfsr_next    = x_q << 1;
    lfsr_next[0] = ^(x_q & TAPS);
  end

  // LFSR runs skip the all-zero state, so they are one vector shorter.
  assign last_count = mode_q ? (N_EXH - ONE) : N_EXH;

`ifdef CG_RESP_LOG_EN
  assign cap_fire  = log_ready;
  assign log_valid = (state_q == S_CAPTURE);
  assign log_x     = x_q;
  assign log_f     = f;
`else
  assign cap_fire  = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    mode_d       = mode_q;
    vec_count_d  = vec_count_q;
    settle_cnt_d = settle_cnt_q;
    misr_clear   = 1'b0;
    misr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_APPLY;
          mode_d      = mode;
          misr_clear  = 1'b1;
          vec_count_d = '0;
          if (!mode)            x_d = '0;
          else if (seed == '0)  x_d = N_IN'(1);
          else                  x_d = seed;
        end
      end
      S_APPLY: begin
        settle_cnt_d = '0;
        state_d      = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
        else                             settle_cnt_d = settle_cnt_q + 4'd1;
      end
      S_CAPTURE: begin
        if (cap_fire) begin
          misr_en     = 1'b1;
          vec_count_d = vec_count_q + ONE;
          if ((vec_count_q + ONE) == last_count) begin
            state_d = S_REPORT;
            x_d     = '0;
          end else begin
            state_d = S_APPLY;
            x_d     = mode_q ? lfsr_next : (x_q + N_IN'(1));
          end
        end
      end
      S_REPORT: begin
        if (rpt_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      mode_q       <= 1'b0;
      vec_count_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      mode_q       <= mode_d;
      vec_count_q  <= vec_count_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  cg_misr #(
    .MISR_W (MISR_W),
    .N_OUT  (N_OUT)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (misr_clear),
    .enable (misr_en),
    .din    (f),
    .sig    (signature)
  );

  assign x         = x_q;
  assign busy      = (state_q != S_IDLE);
  assign rpt_valid = (state_q == S_REPORT);
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_cg_pattern_driver.sv
// Self-checking bench for cg_pattern_driver: randomized runs against a
// behavioural model of the vector sequence and the MISR signature.
module tb_cg_pattern_driver;

  localparam int N_IN   = 7;
  localparam int N_OUT  = 2;
  localparam int MISR_W = 16;
  localparam int SETTLE = 1;
  localparam int VCYC   = 2 + SETTLE;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [N_IN-1:0]   seed;
  logic [N_IN-1:0]   dut_x;
  logic [N_OUT-1:0]  f_in;
  logic              busy;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [MISR_W-1:0] signature;
  logic [N_IN:0]     vec_count;
  int                fsel_r;
  int                n_checks = 0;
  int                n_pass   = 0;

`ifdef CG_RESP_LOG_EN
  logic              log_valid;
  logic              log_ready;
  logic [N_IN-1:0]   log_x;
  logic [N_OUT-1:0]  log_f;
  logic [N_IN+N_OUT-1:0] beats[$];
  always @(posedge clk) if (log_valid && log_ready) beats.push_back({log_x, log_f});
`endif

  always #5 clk = ~clk;

  cg_pattern_driver #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .MISR_W (MISR_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .x         (dut_x),
    .f         (f_in),
    .busy      (busy),
`ifdef CG_RESP_LOG_EN
    .log_valid (log_valid),
    .log_ready (log_ready),
    .log_x     (log_x),
    .log_f     (log_f),
`endif
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .signature (signature),
    .vec_count (vec_count)
  );

  // The circuit under characterisation: three selectable response functions.
  function automatic logic [1:0] circuit(input logic [6:0] v, input int sel);
    case (sel)
      1:       return {v[1], v[0] ^ v[2]};
      2:       return {v[3] & v[5], v[6] | v[0]};
      default: return 2'b00;
    endcase
  endfunction

  assign f_in = circuit(dut_x, fsel_r);

  // x^7 + x^6 + 1 in shift-left form: new bit 0 = old bit 6 xor old bit 5.
  function automatic int lfsr7_step(input int s);
    return ((s * 2) % 128) + (((s / 64) ^ (s / 32)) & 1);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
    int v;
    v = (s * 2) % 65536;
    if (s >= 16'h8000) v = v ^ 'hA011;
    v = v ^ r;
    return v[15:0];
  endfunction

  // Expected vector list for a run.
  task automatic build_vectors(input bit md, input int sd, output int vecs[$]);
    int s;
    vecs.delete();
    if (!md) begin
      for (int i = 0; i < 128; i++) vecs.push_back(i);
    end else begin
      s = (sd == 0) ? 1 : sd;
      for (int i = 0; i < 127; i++) begin
        vecs.push_back(s);
        s = lfsr7_step(s);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; rpt_ready = 1'b0; fsel_r = 0;
`ifdef CG_RESP_LOG_EN
    log_ready = 1'b1;
`endif
    #23;
    n_checks++;
    if ({dut_x, busy, rpt_valid, signature, vec_count} !== '0)
      $display("FAIL reset_state x=%h busy=%b rpt_valid=%b sig=%h cnt=%0d required all zero",
               dut_x, busy, rpt_valid, signature, vec_count);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset busy=%b required 0", busy);
    else n_pass++;
    $display("reset: released, idle");
  endtask

  // One complete run: start, vector schedule, report, optional hold, handshake.
  task automatic run_check(input string name, input bit md, input int sd, input int fsel, input int hold);
    int vecs[$];
    logic [15:0] sig;
    int cyc, xerr, nvec;
    build_vectors(md, sd, vecs);
    nvec = vecs.size();
    sig = '0;
    foreach (vecs[i]) sig = misr_step(sig, circuit(7'(vecs[i]), fsel));
    fsel_r = fsel; mode = md; seed = 7'(sd);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0; seed = '0;
    cyc = 0; xerr = 0;
    while (rpt_valid !== 1'b1 && cyc < nvec * VCYC + 40) begin
      if (cyc % VCYC == 1 && cyc / VCYC < nvec && dut_x !== 7'(vecs[cyc / VCYC])) xerr++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc !== nvec * VCYC) $display("FAIL %s run_length got %0d cycles required %0d", name, cyc, nvec * VCYC);
    else n_pass++;
    n_checks++;
    if (xerr !== 0) $display("FAIL %s x_sequence got %0d wrong vectors required 0", name, xerr);
    else n_pass++;
    n_checks++;
    if (signature !== sig) $display("FAIL %s signature got %h required %h", name, signature, sig);
    else n_pass++;
    n_checks++;
    if (vec_count !== 8'(nvec)) $display("FAIL %s vec_count got %0d required %0d", name, vec_count, nvec);
    else n_pass++;
    n_checks++;
    if ({dut_x, busy} !== {7'd0, 1'b1}) $display("FAIL %s report_state x=%h busy=%b required x=00 busy=1", name, dut_x, busy);
    else n_pass++;
    for (int h = 0; h < hold; h++) begin
      start = (h == hold / 2);
      @(posedge clk); #1;
      n_checks++;
      if ({rpt_valid, busy, signature, vec_count} !== {1'b1, 1'b1, sig, 8'(nvec)})
        $display("FAIL %s report_hold cycle %0d valid=%b busy=%b sig=%h cnt=%0d required 1 1 %h %0d",
                 name, h, rpt_valid, busy, signature, vec_count, sig, nvec);
      else n_pass++;
    end
    // start is also raised in the handshake cycle and must be ignored.
    rpt_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rpt_ready = 1'b0; start = 1'b0;
    n_checks++;
    if ({rpt_valid, busy} !== 2'b00) $display("FAIL %s handshake valid=%b busy=%b required 0 0", name, rpt_valid, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s start_ignored busy=%b required 0", name, busy);
    else n_pass++;
    $display("run %s mode=%0d seed=%0d fsel=%0d hold=%0d sig=%h vecs=%0d", name, md, sd, fsel, hold, signature, nvec);
  endtask

  task automatic test_exhaustive_zero();
    run_check("zero_resp", 1'b0, 0, 0, 0);
  endtask

  task automatic test_loopback();
    run_check("loop_exh", 1'b0, 0, 1, 0);
    run_check("loop_lfsr", 1'b1, 1, 1, 0);
  endtask

  task automatic test_seed_zero();
    run_check("seed_zero", 1'b1, 0, 1, 0);
  endtask

  task automatic test_report_hold();
    run_check("rpt_hold", 1'b1, 1, 1, 20);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_check("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 6)));
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    fsel_r = 2; mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 50 * VCYC + 1) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (dut_x !== 7'd50) $display("FAIL mid_run_vector x=%0d required 50", dut_x);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dut_x, busy, rpt_valid, signature, vec_count} !== '0)
      $display("FAIL async_reset x=%h busy=%b valid=%b sig=%h cnt=%0d required all zero",
               dut_x, busy, rpt_valid, signature, vec_count);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-run at vector 50");
    run_check("after_reset", 1'b0, 0, 2, 0);
  endtask

`ifdef CG_RESP_LOG_EN
  task automatic test_log();
    int vecs[$];
    logic [15:0] sig;
    int cyc, oerr;
    build_vectors(1'b0, 0, vecs);
    sig = '0;
    foreach (vecs[i]) sig = misr_step(sig, circuit(7'(vecs[i]), 1));
    fsel_r = 1; mode = 1'b0; beats.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(log_valid === 1'b1 && dut_x === 7'd10) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    log_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({dut_x, log_valid} !== {7'd10, 1'b1}) $display("FAIL log_stall x=%0d log_valid=%b required 10 1", dut_x, log_valid);
      else n_pass++;
    end
    log_ready = 1'b1;
    cyc = 0;
    while (rpt_valid !== 1'b1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    oerr = 0;
    foreach (beats[i]) if (i < 128 && beats[i] !== {7'(vecs[i]), circuit(7'(vecs[i]), 1)}) oerr++;
    n_checks++;
    if (beats.size() !== 128) $display("FAIL log_beats got %0d required 128", beats.size());
    else n_pass++;
    n_checks++;
    if (oerr !== 0) $display("FAIL log_order got %0d wrong beats required 0", oerr);
    else n_pass++;
    n_checks++;
    if (signature !== sig) $display("FAIL log_signature got %h required %h", signature, sig);
    else n_pass++;
    rpt_ready = 1'b1;
    @(posedge clk); #1;
    rpt_ready = 1'b0;
    $display("log run beats=%0d sig=%h", beats.size(), signature);
  endtask
`endif

  initial begin
    test_reset();
    test_exhaustive_zero();
    test_loopback();
    test_seed_zero();
    test_report_hold();
    test_random();
    test_reset_mid_run();
`ifdef CG_RESP_LOG_EN
    test_log();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
